expr_eval: RTL and testbench
============================

Name: expr_eval

Overview:
- Downstream companion of the arithmetic-string recognizer: consumes the same 8-bit ASCII character stream, one character per enabled clock.
- Evaluates the expression (single decimal digits, binary '+' and '*', '*' binding tighter than '+') incrementally.
- Publishes the running value whenever the prefix received so far is a complete well-formed expression.
- Flags malformed input and arithmetic overflow; results go to the display/checker stage.

Parameters:
WIDTH, 16, width of result and internal sum/product registers; arithmetic is modulo 2^WIDTH.

Ports:
clk    input   1      clock, rising edge.
clr    input   1      reset, asynchronous, active-high.
en     input   1      character strobe; 'in' is consumed on a rising clk edge only when en=1.
in     input   8      ASCII character: '0'..'9', '+', '*'; any other code is illegal.
value  output  WIDTH  value of the expression prefix ending in the last accepted digit.
valid  output  1      1 when the prefix consumed so far is well-formed and ends in a digit.
err    output  1      sticky; set on the first illegal or misplaced character.
ovf    output  1      sticky; set when any intermediate true result is at least 2^WIDTH.

Behaviour:
- Reset (clr=1, any time, including mid-expression):
  - state=S_START; S=0; P=0.
  - value=0, valid=0, err=0, ovf=0.
  - Reset is asynchronous and overrides en.
- Character classes:
  - DIG = '0'..'9', with d = in-8'h30.
  - OP = '+' or '*'.
  - BAD = everything else.
- Internal registers: S (committed sum of finished terms, WIDTH bits); P (current product term, WIDTH bits).
- States:
  - S_START: expect first digit.
  - S_NUM: last was a digit.
  - S_ADD: last was '+'.
  - S_MUL: last was '*'.
  - S_ERR: terminal.
- Transitions (only when en=1):
  - S_START / S_ADD, on DIG: P<=d; value<=S+d; valid<=1; go to S_NUM.
  - S_MUL, on DIG: P<=P*d; value<=S+P*d; valid<=1; go to S_NUM.
  - S_NUM, on '+': S<=S+P; valid<=0; go to S_ADD.
  - S_NUM, on '*': valid<=0; go to S_MUL.
  - Any other character in S_START/S_NUM/S_ADD/S_MUL: go to S_ERR; err<=1; valid<=0.
  - S_ERR: absorbing for every input; only clr leaves it. value holds, valid=0, err=1.
- Timing:
  - All outputs are registered; the result of the character sampled at edge k is visible after edge k.
  - Latency matches the upstream recognizer, so valid equals the recognizer's out cycle-for-cycle on the same stream with en tied 1.
- en=0: no state, register or output change.
- value holds its last computed result while valid=0 (after an operator or in S_ERR).
- Arithmetic and overflow:
  - Product computed at WIDTH+4 bits; sums at WIDTH+1 bits.
  - If the true P*d or S+P*d or S+P exceeds 2^WIDTH-1, set ovf.
  - Stored values are truncated to the low WIDTH bits.
  - ovf never clears except on clr. Overflow does not set err or drop valid.
- Multiply by '0' zeroes P; a subsequent '*' keeps P=0.
- A trailing operator leaves valid=0 until the next digit. No end-of-string marker; the consumer samples valid/value.

Test Plan:
1. clr pulse, then "2+3*4" with en=1 each cycle:
   - valid sequence 1,0,1,0,1.
   - value after the final edge is 14.
   - err=0, ovf=0.
2. "7*0*5+9" -> final value 9, valid=1; value after "7*0" is 0.
3. "2++3" -> err=1 and valid=0 from the second '+'; the trailing '3' leaves value=2, err=1.
   - Leading "+" or "a" as the first character -> err=1 at once.
4. WIDTH=16, "9*9*9*9*9*9":
   - ovf=1 after the sixth digit, value=7153 (531441 mod 65536), valid=1.
   - "9*9*9*9*9" alone gives 59049 with ovf=0.
5. "1+2" with en=0 for 3 cycles inserted between characters (in driven to 'x' meanwhile) -> result identical to a contiguous stream, value=3.
6. Assert clr asynchronously (between clock edges) after "4*5+" -> outputs zero immediately; then "6" -> value=6, valid=1.

Source files
------------

// File: rtl/expr_eval.sv
// ============================================================================
// Module   : expr_eval
// Purpose  : Incremental evaluator for digit / '+' / '*' ASCII expressions.
// Revision : 1.0
// ============================================================================
`default_nettype none

module expr_eval #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [7:0]       in,
    output logic [WIDTH-1:0] value,
    output logic             valid,
    output logic             err,
    output logic             ovf
);

    typedef enum logic [2:0] {
        S_START = 3'd0,
        S_NUM   = 3'd1,
        S_ADD   = 3'd2,
        S_MUL   = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_s, r_p, r_value;
    logic             r_valid, r_err, r_ovf;

    logic [WIDTH-1:0] w_s_nxt, w_p_nxt, w_value_nxt;
    logic             w_valid_nxt, w_err_nxt, w_ovf_nxt;

    logic             w_dig, w_plus, w_star;
    logic [3:0]       w_d;
    logic [WIDTH+3:0] w_prod;
    logic [WIDTH:0]   w_sum_dig, w_sum_mul, w_sum_p;

    assign w_dig  = (in >= 8'h30) && (in <= 8'h39);
    assign w_plus = (in == 8'h2B);
    assign w_star = (in == 8'h2A);
    assign w_d    = in[3:0];

    // Wide intermediates expose the true result so overflow can be detected.
    assign w_prod    = (WIDTH+4)'(r_p) * (WIDTH+4)'(w_d);
    assign w_sum_dig = {1'b0, r_s} + (WIDTH+1)'(w_d);
    assign w_sum_mul = {1'b0, r_s} + {1'b0, w_prod[WIDTH-1:0]};
    assign w_sum_p   = {1'b0, r_s} + {1'b0, r_p};

    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_p_nxt     = r_p;
        w_value_nxt = r_value;
        w_valid_nxt = r_valid;
        w_err_nxt   = r_err;
        w_ovf_nxt   = r_ovf;
        if (en) begin
            unique case (r_state)
                S_START, S_ADD: begin
                    if (w_dig) begin
                        w_p_nxt     = WIDTH'(w_d);
                        w_value_nxt = w_sum_dig[WIDTH-1:0];
                        w_valid_nxt = 1'b1;
                        w_ovf_nxt   = r_ovf | w_sum_dig[WIDTH];
                        w_state_nxt = S_NUM;
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_ERR;
                    end
                end
                S_MUL: begin
                    if (w_dig) begin
                        w_p_nxt     = w_prod[WIDTH-1:0];
                        w_value_nxt = w_sum_mul[WIDTH-1:0];
                        w_valid_nxt = 1'b1;
                        w_ovf_nxt   = r_ovf | (|w_prod[WIDTH+3:WIDTH]) | w_sum_mul[WIDTH];
                        w_state_nxt = S_NUM;
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_ERR;
                    end
                end
                S_NUM: begin
                    if (w_plus) begin
                        w_s_nxt     = w_sum_p[WIDTH-1:0];
                        w_ovf_nxt   = r_ovf | w_sum_p[WIDTH];
                        w_valid_nxt = 1'b0;
                        w_state_nxt = S_ADD;
                    end else if (w_star) begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = S_MUL;
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_ERR;
                    end
                end
                default: begin
                    w_valid_nxt = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_ERR;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_START;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_s     <= '0;
            r_p     <= '0;
            r_value <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_s     <= w_s_nxt;
            r_p     <= w_p_nxt;
            r_value <= w_value_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign value = r_value;
    assign valid = r_valid;
    assign err   = r_err;
    assign ovf   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_expr_eval.sv
// ============================================================================
// Module   : tb_expr_eval
// Purpose  : Directed vector bench for expr_eval.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_expr_eval;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             clr;
    logic             en;
    logic [7:0]       in;
    logic [WIDTH-1:0] value;
    logic             valid, err, ovf;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic             clr;
        logic             en;
        logic [7:0]       ch;
        logic [WIDTH-1:0] v;
        logic             vld;
        logic             e;
        logic             o;
    } vec_t;

    vec_t tbl[$];

    expr_eval #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .clr   (clr),
        .en    (en),
        .in    (in),
        .value (value),
        .valid (valid),
        .err   (err),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic add(input logic c, input logic e_n, input logic [7:0] ch,
                       input int v, input logic vld, input logic e, input logic o);
        vec_t t;
        t.clr = c; t.en = e_n; t.ch = ch; t.v = WIDTH'(v);
        t.vld = vld; t.e = e; t.o = o;
        tbl.push_back(t);
    endtask

    task automatic rst_vec();
        add(1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chr(input logic [7:0] ch, input int v, input logic vld,
                       input logic e, input logic o);
        add(1'b0, 1'b1, ch, v, vld, e, o);
    endtask

    task automatic idle(input int v, input logic vld);
        add(1'b0, 1'b0, 8'hxx, v, vld, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input logic [WIDTH-1:0] ev,
                         input logic evld, input logic ee, input logic eo);
        total++;
        if (value !== ev || valid !== evld || err !== ee || ovf !== eo) begin
            bad++;
            $display("FAIL %s: got value=%0d valid=%b err=%b ovf=%b, want value=%0d valid=%b err=%b ovf=%b",
                     name, value, valid, err, ovf, ev, evld, ee, eo);
        end
    endtask

    task automatic apply(input logic c, input logic e_n, input logic [7:0] ch);
        @(negedge clk);
        clr = c; en = e_n; in = ch;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        clr = 1'b0; en = 1'b0; in = 8'h00;

        // 2+3*4
        rst_vec();
        chr("2", 2, 1, 0, 0);  chr("+", 2, 0, 0, 0);
        chr("3", 5, 1, 0, 0);  chr("*", 5, 0, 0, 0);
        chr("4", 14, 1, 0, 0);
        // 7*0*5+9
        rst_vec();
        chr("7", 7, 1, 0, 0);  chr("*", 7, 0, 0, 0);
        chr("0", 0, 1, 0, 0);  chr("*", 0, 0, 0, 0);
        chr("5", 0, 1, 0, 0);  chr("+", 0, 0, 0, 0);
        chr("9", 9, 1, 0, 0);
        // 2++3
        rst_vec();
        chr("2", 2, 1, 0, 0);  chr("+", 2, 0, 0, 0);
        chr("+", 2, 0, 1, 0);  chr("3", 2, 0, 1, 0);
        // leading bad characters
        rst_vec();  chr("+", 0, 0, 1, 0);
        rst_vec();  chr("a", 0, 0, 1, 0);
        // 9*9*9*9*9*9 then +1 to show ovf is sticky and harmless
        rst_vec();
        chr("9", 9, 1, 0, 0);      chr("*", 9, 0, 0, 0);
        chr("9", 81, 1, 0, 0);     chr("*", 81, 0, 0, 0);
        chr("9", 729, 1, 0, 0);    chr("*", 729, 0, 0, 0);
        chr("9", 6561, 1, 0, 0);   chr("*", 6561, 0, 0, 0);
        chr("9", 59049, 1, 0, 0);  chr("*", 59049, 0, 0, 0);
        chr("9", 7153, 1, 0, 1);   chr("+", 7153, 0, 0, 1);
        chr("1", 7154, 1, 0, 1);
        // 1+2 with en=0 gaps
        rst_vec();
        chr("1", 1, 1, 0, 0);
        idle(1, 1); idle(1, 1); idle(1, 1);
        chr("+", 1, 0, 0, 0);
        idle(1, 0); idle(1, 0); idle(1, 0);
        chr("2", 3, 1, 0, 0);
        // prefix for the asynchronous clear sequence
        rst_vec();
        chr("4", 4, 1, 0, 0);  chr("*", 4, 0, 0, 0);
        chr("5", 20, 1, 0, 0); chr("+", 20, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].clr, tbl[i].en, tbl[i].ch);
            check($sformatf("vec%0d", i), tbl[i].v, tbl[i].vld, tbl[i].e, tbl[i].o);
        end

        // Asynchronous clear between edges: outputs must drop without a clock.
        @(negedge clk);
        en = 1'b0;
        #2;
        clr = 1'b1;
        #1;
        check("async_clr", '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        clr = 1'b0;
        apply(1'b0, 1'b1, "6");
        check("after_clr_6", 16'd6, 1'b1, 1'b0, 1'b0);

        // Error state absorbs everything, including digits with en=1.
        apply(1'b0, 1'b1, "x");
        check("err_enter", 16'd6, 1'b0, 1'b1, 1'b0);
        apply(1'b0, 1'b1, "8");
        check("err_absorb", 16'd6, 1'b0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
